// File: rtl/coeff_ram_pkg.sv
// Shared constants and FSM state type for the banked coefficient RAM.
package coeff_ram_pkg;
  localparam int NUM_BANKS  = 4;
  localparam int BANK_DEPTH = 11;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 4;
  localparam int MAX_ADDR   = 10;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);
  localparam logic [1:0]        LAST_BANK = 2'(NUM_BANKS - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;
endpackage

// File: rtl/coeff_ram_resp_bank.sv
// One 11x16 coefficient bank: write port, registered read port, written-word mask.
module coeff_bank
  import coeff_ram_pkg::*;
(
  input  logic              iClk12M,
  input  logic              iRst,
  input  logic              iWrEn,
  input  logic              iMaskSet,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  input  logic              iRdEn,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic [DATA_W-1:0] oRdData,
  output logic              oLoaded
);
  logic [DATA_W-1:0]     mem [BANK_DEPTH];
  logic [BANK_DEPTH-1:0] mask;

  // Storage carries no reset; only the clear sweep initialises it.
  always_ff @(posedge iClk12M) begin
    if (iWrEn) mem[iWrAddr] <= iWrData;
  end

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      oRdData <= '0;
      mask    <= '0;
    end else begin
      if (iRdEn)    oRdData       <= mem[iRdAddr];
      if (iMaskSet) mask[iWrAddr] <= 1'b1;
    end
  end

  assign oLoaded = &mask;
endmodule

// File: rtl/coeff_ram_resp.sv
// Four-bank coefficient RAM with single-port access and optional zero-fill
// sweep after reset (enabled by defining COEFF_RAM_CLEAR_EN).
module coeff_ram_resp
  import coeff_ram_pkg::*;
(
  input  logic              iClk12M,
  input  logic              iRst,
  input  logic              iCsnRam,
  input  logic              iWrnRam,
  input  logic [ADDR_W-1:0] iAddrRam,
  input  logic [1:0]        iModuleSel,
  input  logic [DATA_W-1:0] iWtDtRam,
  output logic [DATA_W-1:0] oRdDtRam,
  output logic              oRdValid,
  output logic              oAddrErr,
  output logic              oReady,
  output logic [3:0]        oBankLoaded,
  output logic              oDbgState
);
  // Handshake: an access is accepted on a rising edge where iCsnRam=0 and
  // oReady=1; a read answers with a one-cycle oRdValid on the next cycle.
  state_t      state;
  logic        ready;
  logic        clrWr;
  logic [1:0]  clrBank;
  logic [ADDR_W-1:0] clrAddr;

`ifdef COEFF_RAM_CLEAR_EN
  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      state   <= S_CLEAR;
      ready   <= 1'b0;
      clrBank <= '0;
      clrAddr <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (clrAddr == LAST_ADDR) begin
            clrAddr <= '0;
            if (clrBank == LAST_BANK) begin
              state <= S_READY;
              ready <= 1'b1;
            end else begin
              clrBank <= clrBank + 2'd1;
            end
          end else begin
            clrAddr <= clrAddr + 4'd1;
          end
        end
        default: begin
          state <= S_READY;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign clrWr = (state == S_CLEAR);
`else
  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      state <= S_READY;
      ready <= 1'b1;
    end else begin
      state <= S_READY;
      ready <= 1'b1;
    end
  end

  assign clrWr   = 1'b0;
  assign clrBank = '0;
  assign clrAddr = '0;
`endif

  logic accept, inRange, wrAcc, rdAcc;
  assign accept  = !iCsnRam && ready;
  assign inRange = (iAddrRam <= LAST_ADDR);
  assign wrAcc   = accept && !iWrnRam && inRange;
  assign rdAcc   = accept && iWrnRam;

  logic [DATA_W-1:0] bankData [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic hitSel, hitClr;
    assign hitSel = (iModuleSel == 2'(b));
    assign hitClr = clrWr && (clrBank == 2'(b));

    coeff_bank uBank (
      .iClk12M  (iClk12M),
      .iRst     (iRst),
      .iWrEn    ((wrAcc && hitSel) || hitClr),
      .iMaskSet (wrAcc && hitSel),
      .iWrAddr  (clrWr ? clrAddr : iAddrRam),
      .iWrData  (clrWr ? '0 : iWtDtRam),
      .iRdEn    (rdAcc && inRange && hitSel),
      .iRdAddr  (iAddrRam),
      .oRdData  (bankData[b]),
      .oLoaded  (oBankLoaded[b])
    );
  end

  // Bank select and error flag only move on a completed read, so the
  // output word holds between reads.
  logic [1:0] rdSel;
  logic       rdErr;

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      oRdValid <= 1'b0;
      oAddrErr <= 1'b0;
      rdSel    <= '0;
      rdErr    <= 1'b0;
    end else begin
      oRdValid <= rdAcc;
      oAddrErr <= accept && !inRange;
      if (rdAcc) begin
        rdSel <= iModuleSel;
        rdErr <= !inRange;
      end
    end
  end

  assign oRdDtRam  = rdErr ? '0 : bankData[rdSel];
  assign oReady    = ready;
  assign oDbgState = state;
endmodule
